// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bus: requester handshakes, memory-side strobes and status.
// The arbiter takes the slave modport; the requester/memory environment takes master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_req,   r1_req;
  logic              r0_store, r1_store;
  logic [ADDR_W-1:0] r0_addr,  r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic              r0_ack,   r1_ack;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              r0_err,   r1_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_load, mem_store;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  r0_req, r1_req, r0_store, r1_store, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  mem_rdata, mem_ready,
    output r0_ack, r1_ack, r0_rdata, r1_rdata, r0_err, r1_err,
    output mem_addr, mem_load, mem_store, mem_wdata, busy, grant_id
  );

  modport master (
    output r0_req, r1_req, r0_store, r1_store, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output mem_rdata, mem_ready,
    input  r0_ack, r1_ack, r0_rdata, r1_rdata, r0_err, r1_err,
    input  mem_addr, mem_load, mem_store, mem_wdata, busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters access to one memory port,
// with a per-transaction WAIT timeout and a one-cycle response pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic              last;
  logic              gid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic              any_req, win, tmo, done, resp;

  assign any_req = bus.r0_req | bus.r1_req;
  // On a tie the requester that did not own the previous transaction wins.
  assign win     = (bus.r0_req & bus.r1_req) ? ~last : bus.r1_req;
  assign tmo     = (cnt == 8'(TIMEOUT - 1));
  assign done    = bus.mem_ready | tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = WAIT;
      WAIT:    if (done)    state_nxt = RESP;
      RESP:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      last          <= 1'b1;
      gid           <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_data      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_load  <= 1'b0;
      bus.mem_store <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gid           <= win;
          cnt           <= '0;
          bus.mem_addr  <= win ? bus.r1_addr  : bus.r0_addr;
          bus.mem_wdata <= win ? bus.r1_wdata : bus.r0_wdata;
          bus.mem_load  <= ~(win ? bus.r1_store : bus.r0_store);
          bus.mem_store <=  (win ? bus.r1_store : bus.r0_store);
        end
        WAIT: if (done) begin
          // A ready on the last allowed cycle still counts as a normal completion.
          bus.mem_load  <= 1'b0;
          bus.mem_store <= 1'b0;
          rsp_err       <= ~bus.mem_ready;
          rsp_data      <= (bus.mem_ready & bus.mem_load) ? bus.mem_rdata : '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        RESP: last <= gid;
        default: ;
      endcase
    end
  end

  assign resp         = (state == RESP);
  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = gid;
  assign bus.r0_ack   = resp & ~gid;
  assign bus.r1_ack   = resp &  gid;
  assign bus.r0_rdata = bus.r0_ack ? rsp_data : '0;
  assign bus.r1_rdata = bus.r1_ack ? rsp_data : '0;
  assign bus.r0_err   = bus.r0_ack & rsp_err;
  assign bus.r1_err   = bus.r1_ack & rsp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model drives requesters and memory,
// queues expected per-cycle bus state and responses; a monitor compares them on the falling edge.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int NTX = 250;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic        id;
    logic [DW-1:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic        busy;
    logic        load;
    logic        store;
    logic        gid;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cyc_t;

  rsp_t rsp_q[$];
  cyc_t cyc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // requester-side stimulus state
  logic          rq [2];
  logic          st [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];

  task automatic apply();
    bus.r0_req = rq[0]; bus.r0_store = st[0]; bus.r0_addr = ad[0]; bus.r0_wdata = wd[0];
    bus.r1_req = rq[1]; bus.r1_store = st[1]; bus.r1_addr = ad[1]; bus.r1_wdata = wd[1];
  endtask

  task automatic scramble();
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'($urandom_range(1));
      ad[i] = $urandom;
      wd[i] = $urandom;
    end
  endtask

  task automatic push_cyc(input logic busy, input logic ld, input logic sto, input logic g,
                          input logic [AW-1:0] a, input logic [DW-1:0] w);
    cyc_t e;
    e.cyc = cyc; e.busy = busy; e.load = ld; e.store = sto; e.gid = g; e.addr = a; e.wdata = w;
    cyc_q.push_back(e);
  endtask

  // Monitor: compares whatever the model expects for the current cycle.
  initial begin
    cyc_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
          e = cyc_q.pop_front();
          chk1("busy", bus.busy, e.busy);
          chk1("mem_load", bus.mem_load, e.load);
          chk1("mem_store", bus.mem_store, e.store);
          chk1("grant_id", bus.grant_id, e.gid);
          if (e.load || e.store) begin
            chkd("mem_addr", bus.mem_addr, e.addr);
            chkd("mem_wdata", bus.mem_wdata, e.wdata);
          end
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          r = rsp_q.pop_front();
          chk1("r0_ack", bus.r0_ack, !r.id);
          chk1("r1_ack", bus.r1_ack, r.id);
          chkd("rdata", r.id ? bus.r1_rdata : bus.r0_rdata, r.rdata);
          chk1("err", r.id ? bus.r1_err : bus.r0_err, r.err);
          chkd("other_rdata", r.id ? bus.r0_rdata : bus.r1_rdata, 32'h0);
          chk1("other_err", r.id ? bus.r0_err : bus.r1_err, 1'b0);
        end else begin
          chk1("spurious_ack", bus.r0_ack | bus.r1_ack, 1'b0);
          chkd("idle_rdata", bus.r0_rdata | bus.r1_rdata, 32'h0);
          chk1("idle_err", bus.r0_err | bus.r1_err, 1'b0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic w, op, err, last_m, gid_m;
    logic [AW-1:0] a;
    logic [DW-1:0] wdt, data;
    int d, k, c0, ntx;

    for (int i = 0; i < 2; i++) begin rq[i] = 1'b0; st[i] = 1'b0; ad[i] = '0; wd[i] = '0; end
    apply();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    bus.r0_req = 1'b1;
    bus.r0_addr = 32'h55;

    // Reset state, with a live request that must be ignored
    repeat (2) @(negedge clk);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_mem_load", bus.mem_load, 1'b0);
    chk1("rst_mem_store", bus.mem_store, 1'b0);
    chkd("rst_mem_addr", bus.mem_addr, 32'h0);
    chkd("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk1("rst_grant_id", bus.grant_id, 1'b0);
    chk1("rst_acks", bus.r0_ack | bus.r1_ack, 1'b0);
    chkd("rst_rdata", bus.r0_rdata | bus.r1_rdata, 32'h0);
    chk1("rst_err", bus.r0_err | bus.r1_err, 1'b0);
    apply();
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;

    // Randomized transactions against the transaction-level model
    last_m = 1'b1;
    gid_m  = 1'b0;
    ntx    = 0;
    mon_en = 1'b1;
    while (ntx < NTX || rq[0] || rq[1]) begin
      @(posedge clk); #1;
      if (ntx < NTX)
        for (int i = 0; i < 2; i++)
          if (!rq[i] && $urandom_range(99) < 60) begin
            rq[i] = 1'b1;
            st[i] = 1'($urandom_range(1));
            ad[i] = $urandom;
            wd[i] = $urandom;
          end
      apply();
      bus.mem_ready = 1'($urandom_range(1));
      bus.mem_rdata = $urandom;
      push_cyc(1'b0, 1'b0, 1'b0, gid_m, '0, '0);
      if (rq[0] || rq[1]) begin
        w     = (rq[0] && rq[1]) ? !last_m : rq[1];
        gid_m = w;
        op    = st[w];
        a     = ad[w];
        wdt   = wd[w];
        case ($urandom_range(5))
          0:       d = 0;
          1:       d = TO - 1;
          2:       d = TO;
          3:       d = TO - 2;
          default: d = $urandom_range(TO + 2);
        endcase
        err  = (d >= TO);
        k    = err ? TO : d + 1;
        data = $urandom;
        c0   = cyc;
        rsp_q.push_back('{c0 + k + 1, w, (err || op) ? 32'h0 : data, err});
        for (int j = 1; j <= k; j++) begin
          @(posedge clk); #1;
          scramble();
          apply();
          bus.mem_ready = (!err && j == d + 1);
          bus.mem_rdata = (j == d + 1) ? data : $urandom;
          push_cyc(1'b1, !op, op, w, a, wdt);
        end
        @(posedge clk); #1;
        scramble();
        apply();
        bus.mem_ready = 1'($urandom_range(1));
        bus.mem_rdata = $urandom;
        push_cyc(1'b1, 1'b0, 1'b0, w, '0, '0);
        last_m = w;
        rq[w]  = 1'b0;
        ntx++;
      end
    end
    @(negedge clk); #1;
    mon_en = 1'b0;
    tests++;
    if (rsp_q.size() != 0 || cyc_q.size() != 0) begin
      fails++;
      $display("FAIL queues_drained: %0d responses and %0d cycle entries left, expected 0",
               rsp_q.size(), cyc_q.size());
    end

    // Clean R0 load so R0 is the last-granted requester
    @(posedge clk); #1;
    rq[0] = 1'b1; st[0] = 1'b0; ad[0] = 32'h19; rq[1] = 1'b0;
    apply();
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    chk1("dir_load_strobe", bus.mem_load, 1'b1);
    chkd("dir_load_addr", bus.mem_addr, 32'h19);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk1("dir_r0_ack", bus.r0_ack, 1'b1);
    chkd("dir_r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
    chk1("dir_r1_ack", bus.r1_ack, 1'b0);

    // R0 again; reset two cycles after its grant
    @(posedge clk); #1;
    chk1("dir_idle_between", bus.busy, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("mid_busy", bus.busy, 1'b1);
    chk1("mid_load", bus.mem_load, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_load_drop", bus.mem_load, 1'b0);
    chk1("async_busy_drop", bus.busy, 1'b0);
    rq[1] = 1'b1; st[1] = 1'b1;
    apply();
    repeat (2) begin
      @(posedge clk); #1;
      chk1("rst_no_ack", bus.r0_ack | bus.r1_ack, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_grant_r0", bus.grant_id, 1'b0);
    chk1("post_rst_busy", bus.busy, 1'b1);
    chk1("post_rst_load", bus.mem_load, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
